// File: rtl/bank_request_arbiter_if.sv
// Request/grant bus between per-bank schedulers, the bank request arbiter and the burst handler.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface bank_request_arbiter_if #(
    parameter int NUM_CH     = 16,
    parameter int INDEX_BITS = 7,
    parameter int RA_BITS    = 16,
    parameter int CA_BITS    = 10,
    parameter int DATA_BITS  = 16
);
    localparam int CH_BITS = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            valid;
    logic [NUM_CH-1:0]            type_i;
    logic [NUM_CH*DATA_BITS-1:0]  data_i;
    logic [NUM_CH*INDEX_BITS-1:0] idx_i;
    logic [NUM_CH*RA_BITS-1:0]    row_i;
    logic [NUM_CH*CA_BITS-1:0]    col_i;
    logic [NUM_CH-1:0]            ready;

    logic                         out_valid;
    logic                         out_ready;
    logic                         out_type;
    logic [DATA_BITS-1:0]         out_data;
    logic [INDEX_BITS-1:0]        out_idx;
    logic [RA_BITS-1:0]           out_row;
    logic [CA_BITS-1:0]           out_col;
    logic [CH_BITS-1:0]           out_ch;
    logic [1:0]                   out_ba;
    logic [CH_BITS-3:0]           out_bg;

    modport slave (
        input  valid, type_i, data_i, idx_i, row_i, col_i, out_ready,
        output ready, out_valid, out_type, out_data, out_idx, out_row, out_col,
               out_ch, out_ba, out_bg
    );

    modport master (
        output valid, type_i, data_i, idx_i, row_i, col_i, out_ready,
        input  ready, out_valid, out_type, out_data, out_idx, out_row, out_col,
               out_ch, out_ba, out_bg
    );
endinterface

// File: rtl/bank_request_arbiter.sv
// Round-robin N-channel request arbiter with read/write batching and a one-entry
// output register toward the burst handler.
module bank_request_arbiter #(
    parameter int NUM_CH     = 16,
    parameter int INDEX_BITS = 7,
    parameter int RA_BITS    = 16,
    parameter int CA_BITS    = 10,
    parameter int DATA_BITS  = 16,
    parameter int MAX_BATCH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bank_request_arbiter_if.slave   bus
);
    localparam int CH_BITS = $clog2(NUM_CH);
    localparam int BC_BITS = $clog2(MAX_BATCH + 1);
    localparam logic [BC_BITS-1:0] BATCH_MAX = BC_BITS'(MAX_BATCH);

    typedef enum logic [1:0] {ST_RD, ST_WR, ST_RD2WR, ST_WR2RD} state_e;

    state_e                 state_q, state_d;
    logic [CH_BITS-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BC_BITS-1:0]     batch_cnt_q, batch_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_type_q, out_type_d;
    logic [DATA_BITS-1:0]   out_data_q, out_data_d;
    logic [INDEX_BITS-1:0]  out_idx_q, out_idx_d;
    logic [RA_BITS-1:0]     out_row_q, out_row_d;
    logic [CA_BITS-1:0]     out_col_q, out_col_d;
    logic [CH_BITS-1:0]     out_ch_q, out_ch_d;

    logic [NUM_CH-1:0]      rd_vld, wr_vld, eligible;
    logic                   active, mode_wr, same_pend, opp_pend, exhausted, slot_free;
    logic                   found, grant, switch_mode;
    logic [CH_BITS-1:0]     cand, sel;

    // Arbitration: eligible set, batch exhaustion and round-robin pick from rr_ptr.
    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        rd_vld    = bus.valid & ~bus.type_i;
        wr_vld    = bus.valid & bus.type_i;
        active    = (state_q == ST_RD) || (state_q == ST_WR);
        mode_wr   = (state_q == ST_WR);
        eligible  = '0;
        if (active) eligible = mode_wr ? wr_vld : rd_vld;
        same_pend = |eligible;
        opp_pend  = mode_wr ? |rd_vld : |wr_vld;
        exhausted = (batch_cnt_q == BATCH_MAX) && opp_pend;
        slot_free = !out_valid_q || bus.out_ready;

        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = rr_ptr_q + CH_BITS'(k);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        grant       = active && slot_free && found && !exhausted;
        switch_mode = active && (exhausted || (!same_pend && opp_pend));
    end

    always_comb begin
        bus.ready = '0;
        if (grant) bus.ready[sel] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        batch_cnt_d = batch_cnt_q;
        out_valid_d = out_valid_q;
        out_type_d  = out_type_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_ch_d    = out_ch_q;

        unique case (state_q)
            ST_RD:    if (switch_mode) begin state_d = ST_RD2WR; batch_cnt_d = '0; end
            ST_WR:    if (switch_mode) begin state_d = ST_WR2RD; batch_cnt_d = '0; end
            ST_RD2WR: state_d = ST_WR;
            ST_WR2RD: state_d = ST_RD;
            default:  state_d = ST_RD;
        endcase

        if (grant) begin
            rr_ptr_d = sel + CH_BITS'(1);
            if (batch_cnt_q != BATCH_MAX) batch_cnt_d = batch_cnt_q + BC_BITS'(1);
            out_valid_d = 1'b1;
            out_type_d  = bus.type_i[sel];
            out_data_d  = bus.data_i[int'(sel)*DATA_BITS +: DATA_BITS];
            out_idx_d   = bus.idx_i[int'(sel)*INDEX_BITS +: INDEX_BITS];
            out_row_d   = bus.row_i[int'(sel)*RA_BITS +: RA_BITS];
            out_col_d   = bus.col_i[int'(sel)*CA_BITS +: CA_BITS];
            out_ch_d    = sel;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RD;
            rr_ptr_q    <= '0;
            batch_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_type_q  <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            batch_cnt_q <= batch_cnt_d;
            out_valid_q <= out_valid_d;
            out_type_q  <= out_type_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_type  = out_type_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_ba    = out_ch_q[1:0];
    assign bus.out_bg    = out_ch_q[CH_BITS-1:2];
endmodule
